// File: rtl/lif_membrane_integrator_if.sv
// Sample/parameter bus into the LIF membrane integrator and its
// spike, potential and refractory outputs.
interface lif_membrane_integrator_if #(
    parameter int N_STAGE   = 6,
    parameter int U_WIDTH   = 12,
    parameter int REFRACT_W = 3
);
    logic                        in_valid;
    logic signed [N_STAGE+1:0]   sum_in;
    logic        [2:0]           leak_shift;
    logic        [U_WIDTH-2:0]   threshold;
    logic        [REFRACT_W-1:0] refractory_period;
    logic                        spike;
    logic signed [U_WIDTH-1:0]   u_out;
    logic                        refractory;

    modport master (
        output in_valid,
        output sum_in,
        output leak_shift,
        output threshold,
        output refractory_period,
        input  spike,
        input  u_out,
        input  refractory
    );

    modport slave (
        input  in_valid,
        input  sum_in,
        input  leak_shift,
        input  threshold,
        input  refractory_period,
        output spike,
        output u_out,
        output refractory
    );
endinterface

// File: rtl/lif_membrane_integrator.sv
// Leaky integrate-and-fire membrane stage: shift leak, saturating
// integration, reset-by-subtraction firing and refractory hold-off.
module lif_membrane_integrator #(
    parameter int N_STAGE   = 6,
    parameter int U_WIDTH   = 12,
    parameter int REFRACT_W = 3
) (
    input  logic clk,
    input  logic reset,
    lif_membrane_integrator_if.slave bus
);
    localparam int SW = N_STAGE + 2;
    localparam int W  = U_WIDTH + 2;

    localparam logic signed [W-1:0] UMAX_W =
        {3'b000, {(U_WIDTH-1){1'b1}}};
    localparam logic signed [W-1:0] UMIN_W =
        {3'b111, {(U_WIDTH-1){1'b0}}};
    localparam logic signed [U_WIDTH-1:0] UMAX =
        {1'b0, {(U_WIDTH-1){1'b1}}};
    localparam logic signed [U_WIDTH-1:0] UMIN =
        {1'b1, {(U_WIDTH-1){1'b0}}};

    typedef enum logic {
        ST_INTEGRATE,
        ST_REFRACTORY
    } state_e;

    logic signed [U_WIDTH-1:0]   u_q, u_d;
    logic        [REFRACT_W-1:0] rcnt_q, rcnt_d;
    logic                        spike_q, spike_d;

    state_e                      state;
    logic signed [W-1:0]         u_ext;
    logic signed [W-1:0]         sum_ext;
    logic signed [W-1:0]         leak;
    logic signed [W-1:0]         raw;
    logic signed [W-1:0]         thr_ext;
    logic signed [W-1:0]         sat_ext;
    logic signed [U_WIDTH-1:0]   sat;
    logic signed [U_WIDTH-1:0]   thr_u;
    logic                        fire;

    // Operating mode follows directly from the refractory counter.
    always_comb begin
        state = (rcnt_q != '0) ? ST_REFRACTORY : ST_INTEGRATE;
    end

    // Leak, integrate and saturate in a widened signed domain.
    always_comb begin
        u_ext   = {{2{u_q[U_WIDTH-1]}}, u_q};
        sum_ext = {{(W-SW){bus.sum_in[SW-1]}}, bus.sum_in};
        thr_ext = {3'b000, bus.threshold};
        thr_u   = {1'b0, bus.threshold};
        leak    = '0;
        if (bus.leak_shift != 3'd0) begin
            leak = u_ext >>> bus.leak_shift;
        end
        raw = u_ext - leak;
        if (state == ST_INTEGRATE) begin
            raw = raw + sum_ext;
        end
        if (raw > UMAX_W) begin
            sat = UMAX;
        end else if (raw < UMIN_W) begin
            sat = UMIN;
        end else begin
            sat = raw[U_WIDTH-1:0];
        end
        sat_ext = {{2{sat[U_WIDTH-1]}}, sat};
        fire    = (state == ST_INTEGRATE)
                && (bus.threshold != '0)
                && (sat_ext >= thr_ext);
    end

    // Next-state selection; idle cycles hold u and rcnt.
    always_comb begin
        u_d     = u_q;
        rcnt_d  = rcnt_q;
        spike_d = 1'b0;
        if (bus.in_valid) begin
            if (fire) begin
                u_d     = sat - thr_u;
                rcnt_d  = bus.refractory_period;
                spike_d = 1'b1;
            end else begin
                u_d = sat;
                if (state == ST_REFRACTORY) begin
                    rcnt_d = rcnt_q - 1'b1;
                end
            end
        end
    end

    // State registers with synchronous reset taking priority.
    always_ff @(posedge clk) begin
        if (reset) begin
            u_q     <= '0;
            rcnt_q  <= '0;
            spike_q <= 1'b0;
        end else begin
            u_q     <= u_d;
            rcnt_q  <= rcnt_d;
            spike_q <= spike_d;
        end
    end

    assign bus.u_out      = u_q;
    assign bus.spike      = spike_q;
    assign bus.refractory = (rcnt_q != '0);
endmodule
